pam4_tx_mapper: RTL and testbench
=================================

// Module: pam4_tx_mapper
// PURPOSE
//  Transmit-side 4-PAM symbol mapper, the far end of the receiver's decision/power-estimation chain.
//  - Accepts 2-bit symbols over a valid/ready handshake and buffers them in a small FIFO.
//  - Frames the symbol stream as an LFSR training preamble followed by data.
//  - Maps each symbol to a signed 18-bit amplitude, one per clk_en strobe.
//  - Accumulates transmitted mean |amplitude| per frame for loopback comparison against the receiver's ref_level.
// PARAMETERS
//  FIFO_DEPTH  4       symbol FIFO entries (power of 2, >=2)
//  PRE_LEN     64      preamble symbols per frame (0 allowed, < FRAME_LEN)
//  FRAME_LEN   1024    total symbols per frame incl. preamble (power of 2)
//  LFSR_SEED   9'h1FF  preamble LFSR seed, reloaded at every frame start
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  clk_en       in   1   symbol strobe; one symbol emitted per high cycle
//  enable       in   1   start/continue framing
//  ref_level    in   18  signed amplitude unit b (1s17); values <0 treated as 0
//  sym_in       in   2   data symbol
//  sym_valid    in   1   sym_in valid
//  sym_ready    out  1   FIFO can accept (= !full)
//  tx_sym       out  18  signed output amplitude
//  tx_valid     out  1   tx_sym updated this cycle
//  frame_start  out  1   with first symbol of frame
//  clear_accum  out  1   with last symbol of frame (index FRAME_LEN-1)
//  underrun     out  1   sticky: data slot found FIFO empty
//  tx_mean_abs  out  18  mean |tx_sym| of last completed frame
// BEHAVIOUR
//  - Reset (async, active-low):
//    - Outputs tx_sym, tx_valid, frame_start, clear_accum, underrun and tx_mean_abs = 0.
//    - sym_ready = 1 once reset is released.
//    - FIFO empty, state IDLE, counters 0, LFSR = LFSR_SEED.
//    - Reset mid-frame aborts the frame; no clear_accum is issued.
//  - Handshake and FIFO:
//    - Write when sym_valid & sym_ready.
//    - Read only on a DATA-slot clk_en with the FIFO non-empty.
//    - Write and read in the same cycle are both honoured; there is no bypass.
//    - A write into an empty FIFO is not visible to a read in the same cycle.
//  - Gray map: 00->-3b, 01->-b, 11->+b, 10->+3b.
//    - 3b = b + (b<<1) computed at 20 bits, then saturated to [-131071, +131071].
//  - FSM IDLE/PREAMBLE/DATA; every transition and output update happens only on clk_en cycles.
//    - IDLE: on clk_en & enable, go to PREAMBLE (or DATA if PRE_LEN=0). Symbol index 0 is emitted on this same strobe.
//    - PREAMBLE: the symbol is the Gray map of lfsr[1:0]. The LFSR (x^9+x^5+1) steps once per symbol; after PRE_LEN symbols, go to DATA.
//    - DATA: the symbol comes from the FIFO head. If the FIFO is empty: tx_sym = 0 and underrun is set.
//    - After index FRAME_LEN-1: if enable, the next clk_en starts a new frame; else go to IDLE.
//    - Deasserting enable mid-frame lets the frame complete.
//  - Timing:
//    - tx_sym, frame_start and clear_accum are registered at the clk_en edge.
//    - tx_valid is a 1-cycle pulse in the cycle after each emitting clk_en; the other flags are aligned with it.
//  - underrun: sticky; cleared with each frame_start.
//  - Power accumulation:
//    - acc (18+log2(FRAME_LEN) bits, unsigned) adds |symbol| for every emitted symbol, zeros included.
//    - At frame end: tx_mean_abs <= (acc_incl_last) >> log2(FRAME_LEN), and acc restarts at 0.
//    - tx_mean_abs holds its value until the next frame end.
//    - For equiprobable data, tx_mean_abs ~= 2b.
// STRUCTURE
//  - Package pam4_tx_pkg: SYM_W=18; Gray map constants; AMP_MAX=18'sh1FFFF; LFSR taps and seed default; FSM state enum.
//  - Sub-module pam4_sym_fifo: synchronous FIFO with write/read, full/empty and a level counter.
//  - Top contains the FSM, LFSR, mapper/saturation logic and power accumulator.
// TESTING
//  1. PRE_LEN=4, FRAME_LEN=16, b=10000, enable=1, clk_en every 4th cycle -> frame_start with first tx_valid; 4 preamble values equal the model LFSR map from seed 1FF.
//  2. PRE_LEN=0; push 00,01,11,10 -> tx_sym -30000, -10000, +10000, +30000 on successive tx_valid.
//  3. b=50000, symbols 10,00 -> +131071, -131071 (saturated); b=-5 -> tx_sym 0.
//  4. Stall sym_valid during DATA -> tx_sym 0, underrun=1, held through the frame, cleared at next frame_start.
//  5. PRE_LEN=0, FRAME_LEN=16, 16 x '10', b=10000 -> clear_accum with 16th symbol, tx_mean_abs=30000.
//  6. Fill FIFO (sym_ready=0), then drop reset mid-frame -> all outputs 0 immediately; FIFO empty; after release and enable -> fresh frame_start with LFSR reseeded.

Source files
------------

// File: rtl/pam4_tx_pkg.sv
// pam4_tx_pkg: shared definitions for the PAM4 transmit mapper.
//  - SYM_W          : width of the signed output amplitude
//  - GRAY_*         : 2-bit Gray codes of the four amplitude levels
//  - AMP_MAX        : largest magnitude an amplitude may take
//  - LFSR_*         : preamble generator taps and default seed
//  - tx_state_e     : framing FSM states
//  - lfsr_next()    : one step of the x^9+x^5+1 preamble generator
//  - gray_map()     : Gray symbol to saturated signed amplitude
package pam4_tx_pkg;

  localparam int SYM_W = 18;

  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  localparam logic signed [SYM_W-1:0] AMP_MAX = 18'sh1FFFF;

  localparam int         LFSR_TAP_HI   = 8;
  localparam int         LFSR_TAP_LO   = 4;
  localparam logic [8:0] LFSR_SEED_DEF = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } tx_state_e;

  // Fibonacci step: shift left, feedback = bit8 ^ bit4 (x^9 + x^5 + 1).
  function automatic logic [8:0] lfsr_next(input logic [8:0] s);
    return {s[7:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // Map a Gray symbol to +-b / +-3b; a negative unit b counts as zero.
  // 3b is formed at 20 bits so the saturation can see the overflow.
  function automatic logic signed [SYM_W-1:0] gray_map(input logic [1:0] sym,
                                                        input logic signed [SYM_W-1:0] b);
    logic signed [SYM_W+1:0] b_w;
    logic signed [SYM_W+1:0] b3_w;
    logic signed [SYM_W+1:0] amp_w;
    logic signed [SYM_W+1:0] max_w;
    logic signed [SYM_W-1:0] res;
    max_w = {2'b00, AMP_MAX};
    if (b[SYM_W-1]) begin
      b_w = '0;
    end else begin
      b_w = {2'b00, b};
    end
    b3_w = b_w + (b_w <<< 1);
    case (sym)
      GRAY_M3: amp_w = -b3_w;
      GRAY_M1: amp_w = -b_w;
      GRAY_P1: amp_w = b_w;
      GRAY_P3: amp_w = b3_w;
      default: amp_w = '0;
    endcase
    if (amp_w > max_w) begin
      res = AMP_MAX;
    end else if (amp_w < -max_w) begin
      res = -AMP_MAX;
    end else begin
      res = amp_w[SYM_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pam4_sym_fifo.sv
// pam4_sym_fifo: small synchronous FIFO for 2-bit symbols.
//  clk, reset (async, active-low)
//  wr_en / wr_data : write request, ignored while full
//  rd_en / rd_data : read request, ignored while empty; rd_data shows the head
//  full / empty    : decoded from the registered level counter
// No bypass: a word written into an empty FIFO is readable one cycle later.
module pam4_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [W-1:0]      mem_r [DEPTH];
  logic [ADDR_W-1:0] wptr_r;
  logic [ADDR_W-1:0] rptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  assign full    = (level_r == LVL_W'(DEPTH));
  assign empty   = (level_r == '0);
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign rd_data = mem_r[rptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wptr_r] <= wr_data;
        wptr_r        <= wptr_r + ADDR_W'(1);
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + ADDR_W'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/pam4_tx_mapper.sv
// pam4_tx_mapper: PAM4 transmit symbol mapper with framing and power monitor.
//  clk, reset (async, active-low)
//  clk_en      : symbol strobe, one symbol leaves per high cycle while framing
//  enable      : start / continue framing (a running frame always completes)
//  ref_level   : signed amplitude unit b
//  sym_in, sym_valid, sym_ready : data symbol handshake into the FIFO
//  tx_sym, tx_valid             : amplitude and its one-cycle valid pulse
//  frame_start, clear_accum     : first / last symbol of the frame
//  underrun    : sticky, a data slot found the FIFO empty; cleared per frame
//  tx_mean_abs : mean |tx_sym| of the last completed frame
// A frame is PRE_LEN LFSR preamble symbols followed by data from the FIFO.
module pam4_tx_mapper
  import pam4_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         PRE_LEN    = 64,
  parameter int         FRAME_LEN  = 1024,
  parameter logic [8:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic signed [SYM_W-1:0] ref_level,
  input  logic [1:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [SYM_W-1:0] tx_sym,
  output logic                    tx_valid,
  output logic                    frame_start,
  output logic                    clear_accum,
  output logic                    underrun,
  output logic [SYM_W-1:0]        tx_mean_abs
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam int               ACC_W    = SYM_W + IDX_W;
  localparam logic             HAS_PRE  = (PRE_LEN > 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  // Index of the last preamble symbol; only meaningful when HAS_PRE.
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_LEN - 1);

  tx_state_e               state_r, state_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic [8:0]              lfsr_r, lfsr_nxt_s;
  logic [ACC_W-1:0]        acc_r;
  logic [ACC_W-1:0]        acc_sum_s;
  logic signed [SYM_W-1:0] tx_sym_r;
  logic                    tx_valid_r, frame_start_r, clear_accum_r, underrun_r;
  logic [SYM_W-1:0]        tx_mean_abs_r;

  logic                    emit_s, pre_slot_s, first_s, last_s, ur_evt_s;
  logic                    fifo_rd_s, fifo_full_s, fifo_empty_s;
  logic [1:0]              fifo_data_s;
  logic signed [SYM_W-1:0] amp_s;
  logic [SYM_W-1:0]        amp_abs_s;

  pam4_sym_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (sym_valid),
    .wr_data (sym_in),
    .rd_en   (fifo_rd_s),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign sym_ready   = ~fifo_full_s;
  assign tx_sym      = tx_sym_r;
  assign tx_valid    = tx_valid_r;
  assign frame_start = frame_start_r;
  assign clear_accum = clear_accum_r;
  assign underrun    = underrun_r;
  assign tx_mean_abs = tx_mean_abs_r;

  assign first_s = (idx_r == '0);
  assign last_s  = (idx_r == LAST_IDX);

  // Slot decode: whether this strobe emits, and whether it is a preamble slot.
  always_comb begin
    emit_s     = 1'b0;
    pre_slot_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        emit_s     = clk_en & enable;
        pre_slot_s = HAS_PRE;
      end
      ST_PREAMBLE: begin
        emit_s     = clk_en;
        pre_slot_s = 1'b1;
      end
      ST_DATA: begin
        emit_s     = clk_en;
        pre_slot_s = 1'b0;
      end
      default: begin
        emit_s     = 1'b0;
        pre_slot_s = 1'b0;
      end
    endcase
  end

  // Symbol selection, mapping and magnitude for the accumulator.
  always_comb begin
    fifo_rd_s = emit_s & ~pre_slot_s & ~fifo_empty_s;
    ur_evt_s  = ~pre_slot_s & fifo_empty_s;
    if (pre_slot_s) begin
      amp_s = gray_map(lfsr_r[1:0], ref_level);
    end else if (!fifo_empty_s) begin
      amp_s = gray_map(fifo_data_s, ref_level);
    end else begin
      amp_s = '0;
    end
    if (amp_s[SYM_W-1]) begin
      amp_abs_s = -amp_s;
    end else begin
      amp_abs_s = amp_s;
    end
    acc_sum_s = acc_r + {{IDX_W{1'b0}}, amp_abs_s};
  end

  // Framing FSM next state, symbol index and preamble LFSR.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    lfsr_nxt_s  = lfsr_r;
    if (emit_s) begin
      if (last_s) begin
        idx_nxt_s  = '0;
        lfsr_nxt_s = LFSR_SEED;
        if (enable) begin
          state_nxt_s = HAS_PRE ? ST_PREAMBLE : ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
        if (pre_slot_s) begin
          lfsr_nxt_s = lfsr_next(lfsr_r);
        end else begin
          lfsr_nxt_s = lfsr_r;
        end
        if (HAS_PRE && (idx_r < PRE_LAST)) begin
          state_nxt_s = ST_PREAMBLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, output and accumulator registers; everything advances on emitting strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      lfsr_r        <= LFSR_SEED;
      acc_r         <= '0;
      tx_sym_r      <= '0;
      tx_valid_r    <= 1'b0;
      frame_start_r <= 1'b0;
      clear_accum_r <= 1'b0;
      underrun_r    <= 1'b0;
      tx_mean_abs_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      lfsr_r  <= lfsr_nxt_s;
      if (emit_s) begin
        tx_sym_r      <= amp_s;
        tx_valid_r    <= 1'b1;
        frame_start_r <= first_s;
        clear_accum_r <= last_s;
        // The first symbol of a frame clears the sticky flag before adding its own event.
        underrun_r    <= (first_s ? 1'b0 : underrun_r) | ur_evt_s;
        if (last_s) begin
          acc_r         <= '0;
          tx_mean_abs_r <= acc_sum_s[ACC_W-1:IDX_W];
        end else begin
          acc_r <= acc_sum_s;
        end
      end else begin
        tx_valid_r    <= 1'b0;
        frame_start_r <= 1'b0;
        clear_accum_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pam4_tx_mapper.sv
// tb_pam4_tx_mapper: randomized bench for pam4_tx_mapper.
// Two instances share the stimulus: dut_a frames 4 preamble + 12 data symbols,
// dut_b frames 16 data symbols. Each is compared every cycle with a behavioural
// model built from queues and integer arithmetic.
module tb_pam4_tx_mapper;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic               enable;
  logic               sym_valid;
  logic [1:0]         sym_in;
  logic signed [17:0] ref_level;

  logic               sym_ready_a, tx_valid_a, frame_start_a, clear_accum_a, underrun_a;
  logic signed [17:0] tx_sym_a;
  logic [17:0]        mean_a;
  logic               sym_ready_b, tx_valid_b, frame_start_b, clear_accum_b, underrun_b;
  logic signed [17:0] tx_sym_b;
  logic [17:0]        mean_b;

  int total = 0;
  int bad   = 0;

  // model state, index 0 -> dut_a, 1 -> dut_b
  int     m_pre [2] = '{4, 0};
  int     mq [2][$];
  int     m_idx [2];
  int     m_lfsr [2];
  int     m_run [2];
  longint m_acc [2];
  int     e_sym [2];
  int     e_val [2];
  int     e_fs [2];
  int     e_clr [2];
  int     e_und [2];
  int     e_mean [2];

  always #5 clk = ~clk;

  pam4_tx_mapper #(.FIFO_DEPTH(4), .PRE_LEN(4), .FRAME_LEN(16), .LFSR_SEED(9'h1FF)) dut_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable), .ref_level(ref_level),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready_a), .tx_sym(tx_sym_a),
    .tx_valid(tx_valid_a), .frame_start(frame_start_a), .clear_accum(clear_accum_a),
    .underrun(underrun_a), .tx_mean_abs(mean_a)
  );

  pam4_tx_mapper #(.FIFO_DEPTH(4), .PRE_LEN(0), .FRAME_LEN(16), .LFSR_SEED(9'h1FF)) dut_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable), .ref_level(ref_level),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready_b), .tx_sym(tx_sym_b),
    .tx_valid(tx_valid_b), .frame_start(frame_start_b), .clear_accum(clear_accum_b),
    .underrun(underrun_b), .tx_mean_abs(mean_b)
  );

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int amp(input int s, input int b);
    int bb;
    int v;
    bb = (b < 0) ? 0 : b;
    case (s)
      0:       v = -3 * bb;
      1:       v = -bb;
      3:       v = bb;
      default: v = 3 * bb;
    endcase
    if (v > 131071) v = 131071;
    if (v < -131071) v = -131071;
    return v;
  endfunction

  function automatic int lfsr_step(input int l);
    return ((l << 1) | (((l >> 8) ^ (l >> 4)) & 1)) & 'h1FF;
  endfunction

  task automatic model_reset(input int m);
    mq[m].delete();
    m_idx[m] = 0; m_lfsr[m] = 'h1FF; m_run[m] = 0; m_acc[m] = 0;
    e_sym[m] = 0; e_val[m] = 0; e_fs[m] = 0; e_clr[m] = 0; e_und[m] = 0; e_mean[m] = 0;
  endtask

  // Effect of one rising edge with the currently applied inputs.
  task automatic model_step(input int m);
    bit wr;
    bit ev;
    int v;
    wr = sym_valid && (mq[m].size() < 4);
    e_val[m] = 0; e_fs[m] = 0; e_clr[m] = 0;
    if (clk_en && (m_run[m] != 0 || enable)) begin
      v = 0; ev = 0;
      if (m_idx[m] < m_pre[m]) begin
        v = amp(m_lfsr[m] & 3, ref_level);
        m_lfsr[m] = lfsr_step(m_lfsr[m]);
      end else if (mq[m].size() > 0) begin
        v = amp(mq[m].pop_front(), ref_level);
      end else begin
        ev = 1;
      end
      e_sym[m] = v;
      e_val[m] = 1;
      e_fs[m]  = (m_idx[m] == 0);
      e_clr[m] = (m_idx[m] == 15);
      e_und[m] = ((m_idx[m] == 0) ? 0 : e_und[m]) | ev;
      m_acc[m] += (v < 0) ? -v : v;
      if (m_idx[m] == 15) begin
        e_mean[m] = int'(m_acc[m] / 16);
        m_acc[m]  = 0;
        m_lfsr[m] = 'h1FF;
        m_run[m]  = enable ? 1 : 0;
        m_idx[m]  = 0;
      end else begin
        m_idx[m]++;
        m_run[m] = 1;
      end
    end
    if (wr) mq[m].push_back(sym_in);
  endtask

  task automatic compare();
    check_val("a.tx_sym", tx_sym_a, e_sym[0]);
    check_val("a.tx_valid", tx_valid_a, e_val[0]);
    check_val("a.frame_start", frame_start_a, e_fs[0]);
    check_val("a.clear_accum", clear_accum_a, e_clr[0]);
    check_val("a.underrun", underrun_a, e_und[0]);
    check_val("a.tx_mean_abs", mean_a, e_mean[0]);
    check_val("a.sym_ready", sym_ready_a, (mq[0].size() < 4) ? 1 : 0);
    check_val("b.tx_sym", tx_sym_b, e_sym[1]);
    check_val("b.tx_valid", tx_valid_b, e_val[1]);
    check_val("b.frame_start", frame_start_b, e_fs[1]);
    check_val("b.clear_accum", clear_accum_b, e_clr[1]);
    check_val("b.underrun", underrun_b, e_und[1]);
    check_val("b.tx_mean_abs", mean_b, e_mean[1]);
    check_val("b.sym_ready", sym_ready_b, (mq[1].size() < 4) ? 1 : 0);
  endtask

  // Apply inputs just after a falling edge, advance the model, check after the next rise.
  task automatic step(input bit ce, input bit en, input bit vl, input logic [1:0] s, input int b);
    clk_en = ce; enable = en; sym_valid = vl; sym_in = s; ref_level = 18'(b);
    if (reset) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    compare();
  endtask

  logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  initial begin
    int bsel;
    reset = 1'b0; clk_en = 1'b0; enable = 1'b0; sym_valid = 1'b0; sym_in = 2'b00;
    ref_level = 18'sd0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    compare();
    reset = 1'b1;

    // framing with strobe every 4th cycle; ordered symbols first, then random
    for (int i = 0; i < 64; i++) begin
      if (i < 4) step((i % 4) == 3, 1'b1, 1'b1, order[i], 10000);
      else step((i % 4) == 3, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10000);
    end

    // saturation with large b, then negative b
    for (int i = 0; i < 24; i++)
      step(i % 2 == 1, 1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 50000);
    for (int i = 0; i < 16; i++)
      step(i % 2 == 1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), -5);

    // stall the source: data slots underrun
    for (int i = 0; i < 40; i++) step(i % 2 == 1, 1'b1, 1'b0, 2'b00, 10000);
    check_val("b.underrun_after_stall", underrun_b, 1);
    for (int i = 0; i < 40; i++) step(i % 2 == 1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 10000);

    // all-'10' frames give mean 3b
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 2'b00, 10000);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, 2'b10, 10000);
    check_val("b.mean_3b", mean_b, 30000);

    // fill FIFO with strobes halted, then reset mid-frame
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 10000);
    check_val("a.ready_full", sym_ready_a, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare();
    @(negedge clk);
    compare();
    reset = 1'b1;
    for (int i = 0; i < 48; i++) step(i % 3 == 2, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 10000);

    // random traffic including enable toggles
    for (int i = 0; i < 800; i++) begin
      bsel = $urandom_range(0, 3);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           (bsel == 0) ? 10000 : (bsel == 1) ? 50000 : (bsel == 2) ? -5 : $urandom_range(0, 131071));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
